// File: rtl/y_pkg.sv
// Shared definitions for the y_ctrl_fsm sequencer: opcodes, ALU op codes,
// state encoding and the control vector.
package y_pkg;

  localparam logic [31:0] RESET_PC    = 32'h28;
  localparam int          MEM_TIMEOUT = 15;

  localparam logic [6:0] OP_R   = 7'h33;
  localparam logic [6:0] OP_I   = 7'h13;
  localparam logic [6:0] OP_LW  = 7'h03;
  localparam logic [6:0] OP_SW  = 7'h23;
  localparam logic [6:0] OP_BEQ = 7'h63;
  localparam logic [6:0] OP_JAL = 7'h6F;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    CL_R, CL_I, CL_LW, CL_SW, CL_BEQ, CL_JAL, CL_BAD
  } iclass_t;

  typedef struct packed {
    logic       reg_write;
    logic       alu_src;
    logic       mem_read;
    logic       mem_write;
    logic       mem2reg;
    logic       link;
    logic [2:0] op;
  } ctrl_t;

  function automatic iclass_t classify(input logic [6:0] opcode);
    case (opcode)
      OP_R:    return CL_R;
      OP_I:    return CL_I;
      OP_LW:   return CL_LW;
      OP_SW:   return CL_SW;
      OP_BEQ:  return CL_BEQ;
      OP_JAL:  return CL_JAL;
      default: return CL_BAD;
    endcase
  endfunction

endpackage

// File: rtl/y_ctrl_decode.sv
// Combinational control decode: registered IR plus current state in,
// Moore control vector and instruction class out.
module y_ctrl_decode import y_pkg::*; (
  input  logic [31:0] ir,
  input  state_t      state,
  output ctrl_t       ctrl,
  output iclass_t     iclass,
  output logic        illegal,
  output logic        ir_zero
);

  logic [2:0] cls_op;
  logic       in_dp;

  assign iclass  = classify(ir[6:0]);
  assign illegal = (iclass == CL_BAD);
  assign ir_zero = (ir == 32'd0);
  assign in_dp   = (state == S_EXEC) || (state == S_MEM) || (state == S_WB);

  always_comb begin
    cls_op = ALU_ADD;
    if (iclass == CL_BEQ) begin
      cls_op = ALU_SUB;
    end else if (iclass == CL_R) begin
      case (ir[14:12])
        3'b000:  cls_op = (ir[31:25] == 7'h20) ? ALU_SUB : ALU_ADD;
        3'b111:  cls_op = ALU_AND;
        3'b110:  cls_op = ALU_OR;
        3'b010:  cls_op = ALU_SLT;
        default: cls_op = ALU_ADD;
      endcase
    end
  end

  // Outside EXEC/MEM/WB every strobe is 0 and the ALU idles on add.
  always_comb begin
    ctrl    = '0;
    ctrl.op = ALU_ADD;
    if (in_dp) begin
      ctrl.alu_src = !((iclass == CL_R) || (iclass == CL_BEQ));
      ctrl.op      = cls_op;
    end
    if (state == S_MEM) begin
      ctrl.mem_read  = (iclass == CL_LW);
      ctrl.mem_write = (iclass == CL_SW);
    end
    if (state == S_WB) begin
      ctrl.reg_write = 1'b1;
      ctrl.mem2reg   = (iclass == CL_LW);
      ctrl.link      = (iclass == CL_JAL);
    end
  end

endmodule

// File: rtl/y_ctrl_fsm.sv
// Multi-cycle control sequencer: owns PC, IR, MEM wait counter and the
// retired-instruction counter; controls are decoded from state and IR.
module y_ctrl_fsm import y_pkg::*; (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] ins,
  input  logic        zero,
  input  logic [31:0] PCp4,
  input  logic [31:0] branch,
  input  logic [31:0] jTarget,
  input  logic        mem_ready,
  output logic [31:0] PCin,
  output logic        RegWrite,
  output logic        ALUSrc,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        Mem2Reg,
  output logic        link,
  output logic [2:0]  op,
  output logic [2:0]  state,
  output logic [31:0] retired,
  output logic        halt,
  output logic        err
);

  state_t      state_q;
  logic [31:0] ir;
  logic [3:0]  wait_cnt;
  ctrl_t       ctrl;
  iclass_t     iclass;
  logic        illegal;
  logic        ir_zero;

  y_ctrl_decode u_decode (
    .ir      (ir),
    .state   (state_q),
    .ctrl    (ctrl),
    .iclass  (iclass),
    .illegal (illegal),
    .ir_zero (ir_zero)
  );

  assign state    = state_q;
  assign RegWrite = ctrl.reg_write;
  assign ALUSrc   = ctrl.alu_src;
  assign MemRead  = ctrl.mem_read;
  assign MemWrite = ctrl.mem_write;
  assign Mem2Reg  = ctrl.mem2reg;
  assign link     = ctrl.link;
  assign op       = ctrl.op;

  // PC and retired only move on the edge that leaves an instruction's last state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_FETCH;
      ir       <= 32'd0;
      PCin     <= RESET_PC;
      wait_cnt <= 4'd0;
      retired  <= 32'd0;
      halt     <= 1'b0;
      err      <= 1'b0;
    end else begin
      case (state_q)
        S_FETCH: begin
          ir      <= ins;
          state_q <= S_DECODE;
        end
        S_DECODE: begin
          if (illegal) begin
            state_q <= S_HALT;
            halt    <= 1'b1;
            err     <= !ir_zero;
          end else begin
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          wait_cnt <= 4'd0;
          case (iclass)
            CL_BEQ: begin
              PCin    <= zero ? branch : PCp4;
              retired <= retired + 32'd1;
              state_q <= S_FETCH;
            end
            CL_LW, CL_SW: state_q <= S_MEM;
            default:      state_q <= S_WB;
          endcase
        end
        S_MEM: begin
          if (mem_ready) begin
            if (iclass == CL_LW) begin
              state_q <= S_WB;
            end else begin
              PCin    <= PCp4;
              retired <= retired + 32'd1;
              state_q <= S_FETCH;
            end
          end else if (wait_cnt == 4'(MEM_TIMEOUT - 1)) begin
            // This low cycle brings the wait count to MEM_TIMEOUT.
            state_q <= S_HALT;
            halt    <= 1'b1;
            err     <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        S_WB: begin
          PCin    <= (iclass == CL_JAL) ? jTarget : PCp4;
          retired <= retired + 32'd1;
          state_q <= S_FETCH;
        end
        S_HALT:  state_q <= S_HALT;
        default: state_q <= S_HALT;
      endcase
    end
  end

endmodule

// File: tb/tb_y_ctrl_fsm.sv
// Self-checking bench for y_ctrl_fsm: per-cycle expected control vectors are
// queued when an instruction is driven and popped as the DUT steps through it.
module tb_y_ctrl_fsm;

  localparam int          W           = 14;
  localparam int          MEM_TIMEOUT = 15;
  localparam logic [31:0] RESET_PC    = 32'h28;

  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_SUB  = 32'h402081B3;
  localparam logic [31:0] I_AND  = 32'h0020F1B3;
  localparam logic [31:0] I_OR   = 32'h0020E1B3;
  localparam logic [31:0] I_SLT  = 32'h0020A1B3;
  localparam logic [31:0] I_ADDI = 32'h00500093;
  localparam logic [31:0] I_LW   = 32'h0000A183;
  localparam logic [31:0] I_SW   = 32'h0020A023;
  localparam logic [31:0] I_BEQ  = 32'h00208463;
  localparam logic [31:0] I_JAL  = 32'h008000EF;
  localparam logic [31:0] I_BAD  = 32'h0000007F;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] ins = 32'd0;
  logic        zero = 1'b0;
  logic [31:0] PCp4;
  logic [31:0] branch = 32'd0;
  logic [31:0] jTarget = 32'd0;
  logic        mem_ready = 1'b0;
  logic [31:0] PCin;
  logic        RegWrite, ALUSrc, MemRead, MemWrite, Mem2Reg, link;
  logic [2:0]  op;
  logic [2:0]  state;
  logic [31:0] retired;
  logic        halt, err;

  logic [W-1:0] exp_q[$];
  logic         drv_q[$];
  int           n_cmp = 0;
  int           n_bad = 0;
  logic [31:0]  exp_pc;
  logic [31:0]  exp_ret;

  always #5 clk = ~clk;

  // Fetch-stage model: the datapath supplies PC+4.
  assign PCp4 = PCin + 32'd4;

  y_ctrl_fsm dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ins       (ins),
    .zero      (zero),
    .PCp4      (PCp4),
    .branch    (branch),
    .jTarget   (jTarget),
    .mem_ready (mem_ready),
    .PCin      (PCin),
    .RegWrite  (RegWrite),
    .ALUSrc    (ALUSrc),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .Mem2Reg   (Mem2Reg),
    .link      (link),
    .op        (op),
    .state     (state),
    .retired   (retired),
    .halt      (halt),
    .err       (err)
  );

  function automatic logic [W-1:0] mk(input logic [2:0] st, input logic rw, input logic as_,
                                      input logic mr, input logic mw, input logic m2r,
                                      input logic lk, input logic [2:0] aop,
                                      input logic h, input logic e);
    return {st, rw, as_, mr, mw, m2r, lk, aop, h, e};
  endfunction

  function automatic logic [W-1:0] obs();
    return {state, RegWrite, ALUSrc, MemRead, MemWrite, Mem2Reg, link, op, halt, err};
  endfunction

  function automatic logic [2:0] model_op(input logic [31:0] i);
    if (i[6:0] == 7'h63) return 3'b110;
    if (i[6:0] != 7'h33) return 3'b010;
    case (i[14:12])
      3'b000:  return (i[31:25] == 7'h20) ? 3'b110 : 3'b010;
      3'b111:  return 3'b000;
      3'b110:  return 3'b001;
      3'b010:  return 3'b111;
      default: return 3'b010;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_cmp++;
    if (got !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, expv);
    end
  endtask

  task automatic push(input logic [W-1:0] e, input logic rdy);
    exp_q.push_back(e);
    drv_q.push_back(rdy);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ins = 32'd0;
    mem_ready = 1'b0;
    zero = 1'b0;
    #2;
    check("rst_ctrl", 32'(obs()), 32'(mk(3'd0, 0, 0, 0, 0, 0, 0, 3'b010, 0, 0)));
    check("rst_pc", PCin, RESET_PC);
    check("rst_retired", retired, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    exp_pc = RESET_PC;
    exp_ret = 32'd0;
  endtask

  task automatic run_instr(input logic [31:0] i, input int waits, input logic z,
                           input logic [31:0] br, input logic [31:0] jt);
    logic [6:0]   opc;
    logic         is_r, is_i, is_lw, is_sw, is_beq, is_jal, legal, as_, rdy;
    logic         halted;
    logic [2:0]   aop;
    logic [W-1:0] e;
    int           step;
    opc = i[6:0];
    is_r = (opc == 7'h33); is_i = (opc == 7'h13); is_lw = (opc == 7'h03);
    is_sw = (opc == 7'h23); is_beq = (opc == 7'h63); is_jal = (opc == 7'h6F);
    legal = is_r | is_i | is_lw | is_sw | is_beq | is_jal;
    as_ = !(is_r || is_beq);
    aop = model_op(i);
    halted = 1'b0;
    step = 0;
    ins = i; zero = z; branch = br; jTarget = jt; mem_ready = 1'b0;

    push(mk(3'd0, 0, 0, 0, 0, 0, 0, 3'b010, 0, 0), 1'b0);
    push(mk(3'd1, 0, 0, 0, 0, 0, 0, 3'b010, 0, 0), 1'b0);
    if (!legal) begin
      push(mk(3'd5, 0, 0, 0, 0, 0, 0, 3'b010, 1, (i != 32'd0)), 1'b0);
      push(mk(3'd5, 0, 0, 0, 0, 0, 0, 3'b010, 1, (i != 32'd0)), 1'b0);
      halted = 1'b1;
    end else begin
      push(mk(3'd2, 0, as_, 0, 0, 0, 0, aop, 0, 0), 1'b0);
      if (is_lw || is_sw) begin
        for (int k = 0; k < MEM_TIMEOUT; k++) begin
          rdy = (k >= waits);
          push(mk(3'd3, 0, as_, is_lw, is_sw, 0, 0, aop, 0, 0), rdy);
          if (rdy) break;
        end
        if (waits >= MEM_TIMEOUT) begin
          push(mk(3'd5, 0, 0, 0, 0, 0, 0, 3'b010, 1, 1), 1'b0);
          push(mk(3'd5, 0, 0, 0, 0, 0, 0, 3'b010, 1, 1), 1'b0);
          halted = 1'b1;
        end
      end
      if (!halted && !is_beq && !is_sw)
        push(mk(3'd4, 1, as_, 0, 0, is_lw, is_jal, aop, 0, 0), 1'b0);
    end

    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      mem_ready = drv_q.pop_front();
      check($sformatf("ctrl_%08h_step%0d", i, step), 32'(obs()), 32'(e));
      @(posedge clk);
      #1;
      step++;
    end
    mem_ready = 1'b0;

    if (!halted) begin
      if (is_beq) exp_pc = z ? br : exp_pc + 32'd4;
      else if (is_jal) exp_pc = jt;
      else exp_pc = exp_pc + 32'd4;
      exp_ret = exp_ret + 32'd1;
    end
    check($sformatf("pc_%08h", i), PCin, exp_pc);
    check($sformatf("retired_%08h", i), retired, exp_ret);
  endtask

  initial begin
    int sel, w, k;
    do_reset();

    run_instr(I_ADD, 0, 1'b0, 32'd0, 32'd0);
    run_instr(I_LW, 3, 1'b0, 32'd0, 32'd0);
    run_instr(I_BEQ, 0, 1'b1, 32'h40, 32'd0);
    run_instr(I_BEQ, 0, 1'b0, 32'h80, 32'd0);
    run_instr(I_JAL, 0, 1'b0, 32'd0, 32'h60);
    run_instr(I_ADDI, 0, 1'b0, 32'd0, 32'd0);
    run_instr(I_SUB, 0, 1'b0, 32'd0, 32'd0);
    run_instr(I_AND, 0, 1'b0, 32'd0, 32'd0);
    run_instr(I_OR, 0, 1'b0, 32'd0, 32'd0);
    run_instr(I_SLT, 0, 1'b0, 32'd0, 32'd0);
    run_instr(I_SW, 0, 1'b0, 32'd0, 32'd0);
    run_instr(I_LW, MEM_TIMEOUT - 1, 1'b0, 32'd0, 32'd0);
    for (int n = 0; n < 8; n++) begin
      sel = $urandom_range(0, 2);
      w = $urandom_range(0, 4);
      case (sel)
        0:       run_instr(I_LW, w, 1'b0, 32'd0, 32'd0);
        1:       run_instr(I_SW, w, 1'b0, 32'd0, 32'd0);
        default: run_instr(I_ADD, 0, 1'b0, 32'd0, 32'd0);
      endcase
    end
    run_instr(I_SW, MEM_TIMEOUT + 5, 1'b0, 32'd0, 32'd0);

    do_reset();
    run_instr(32'd0, 0, 1'b0, 32'd0, 32'd0);
    do_reset();
    run_instr(I_BAD, 0, 1'b0, 32'd0, 32'd0);

    // Reset in the middle of a store access.
    do_reset();
    run_instr(I_ADD, 0, 1'b0, 32'd0, 32'd0);
    ins = I_SW;
    mem_ready = 1'b0;
    k = 0;
    while (state != 3'd3 && k < 10) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("mid_mem_state", 32'(state), 32'd3);
    check("mid_mem_write", 32'(MemWrite), 32'd1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("rst_mem_write", 32'(MemWrite), 32'd0);
    check("rst_mem_pc", PCin, RESET_PC);
    check("rst_mem_retired", retired, 32'd0);
    check("rst_mem_state", 32'(state), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_pc = RESET_PC;
    exp_ret = 32'd0;
    run_instr(I_ADD, 0, 1'b0, 32'd0, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
